// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline constants and control-field encodings for the writeback side.
package pipe_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } reg_src_e;

   typedef enum logic {
      WB_WORD = 1'b0,
      WB_BYTE = 1'b1
   } word_byte_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-stage to MEM/WB bundle: instruction fields, aligned read data and pipeline control.
interface mem_wb_stage_if #(
   parameter int unsigned DATA_W = pipe_pkg::DATA_W,
   parameter int unsigned REG_AW = pipe_pkg::REG_AW
);
   logic              ex_mem_valid;
   logic              ex_mem_RegWrite;
   logic              ex_mem_RegSrc;
   logic              ex_mem_word_byte;
   logic [DATA_W-1:0] ex_mem_ALUOut_EXEC;
   logic [REG_AW-1:0] ex_mem_write_reg_dest;
   logic [DATA_W-1:0] Read_data;
   logic              stall;
   logic              flush;

   modport master (
      output ex_mem_valid, ex_mem_RegWrite, ex_mem_RegSrc, ex_mem_word_byte,
      output ex_mem_ALUOut_EXEC, ex_mem_write_reg_dest, Read_data, stall, flush
   );

   modport slave (
      input ex_mem_valid, ex_mem_RegWrite, ex_mem_RegSrc, ex_mem_word_byte,
      input ex_mem_ALUOut_EXEC, ex_mem_write_reg_dest, Read_data, stall, flush
   );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Combinational little-endian byte-lane select with sign extension; word loads pass through.
module load_extract #(
   parameter int unsigned DATA_W = pipe_pkg::DATA_W
) (
   input  logic              word_byte_i,
   input  logic [1:0]        lane_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] data_o
);
   import pipe_pkg::*;

   logic [7:0] byte_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      unique case (lane_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
   end

   always_comb begin
      if (word_byte_e'(word_byte_i) == WB_BYTE) begin
         data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      end else begin
         data_o = rdata_i;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select and forwarding source.
// Optional retire counter / last-destination tag built only with MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
   parameter int unsigned DATA_W = pipe_pkg::DATA_W,
   parameter int unsigned REG_AW = pipe_pkg::REG_AW
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   mem_wb_stage_if.slave     ex_mem,
   output logic              mem_wb_out_valid,
   output logic              mem_wb_out_RegWrite,
   output logic              mem_wb_out_RegSrc,
   output logic [DATA_W-1:0] mem_wb_out_ALUOut_EXEC,
   output logic [DATA_W-1:0] mem_wb_out_Mem_dataOut,
   output logic [REG_AW-1:0] mem_wb_out_write_reg_dest,
   output logic [DATA_W-1:0] write_data,
   output logic              reg_we,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_reg,
   output logic [DATA_W-1:0] fwd_data
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [REG_AW-1:0] last_dest
`endif
);
   import pipe_pkg::*;

   logic              valid_q, valid_d;
   logic              rw_q,    rw_d;
   logic              src_q,   src_d;
   logic [DATA_W-1:0] alu_q,   alu_d;
   logic [DATA_W-1:0] mem_q,   mem_d;
   logic [REG_AW-1:0] dest_q,  dest_d;
   logic [DATA_W-1:0] ext_data;

   load_extract #(
      .DATA_W (DATA_W)
   ) u_load_extract (
      .word_byte_i (ex_mem.ex_mem_word_byte),
      .lane_i      (ex_mem.ex_mem_ALUOut_EXEC[1:0]),
      .rdata_i     (ex_mem.Read_data),
      .data_o      (ext_data)
   );

   // flush beats stall; rst is applied in the register process on top of this
   always_comb begin
      valid_d = valid_q;
      rw_d    = rw_q;
      src_d   = src_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      dest_d  = dest_q;
      if (ex_mem.flush) begin
         valid_d = 1'b0;
         rw_d    = 1'b0;
         src_d   = 1'b0;
         alu_d   = '0;
         mem_d   = '0;
         dest_d  = '0;
      end else if (!ex_mem.stall) begin
         valid_d = ex_mem.ex_mem_valid;
         rw_d    = ex_mem.ex_mem_RegWrite & ex_mem.ex_mem_valid;
         src_d   = ex_mem.ex_mem_RegSrc;
         alu_d   = ex_mem.ex_mem_ALUOut_EXEC;
         mem_d   = (reg_src_e'(ex_mem.ex_mem_RegSrc) == SRC_MEM) ? ext_data : '0;
         dest_d  = ex_mem.ex_mem_write_reg_dest;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         src_q   <= 1'b0;
         alu_q   <= '0;
         mem_q   <= '0;
         dest_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rw_q    <= rw_d;
         src_q   <= src_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         dest_q  <= dest_d;
      end
   end

   assign mem_wb_out_valid          = valid_q;
   assign mem_wb_out_RegWrite       = rw_q;
   assign mem_wb_out_RegSrc         = src_q;
   assign mem_wb_out_ALUOut_EXEC    = alu_q;
   assign mem_wb_out_Mem_dataOut    = mem_q;
   assign mem_wb_out_write_reg_dest = dest_q;

   assign write_data = (reg_src_e'(src_q) == SRC_MEM) ? mem_q : alu_q;
   assign reg_we     = rw_q & (dest_q != '0);

   assign fwd_valid = reg_we;
   assign fwd_reg   = dest_q;
   assign fwd_data  = write_data;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [REG_AW-1:0] last_q, last_d;

   // an instruction retires when it leaves WB: valid and not held by stall
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (valid_q && !ex_mem.stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (reg_we) begin
         last_d = dest_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign retire_cnt = cnt_q;
   assign last_dest  = last_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed corner sequences, random vs model.
module tb_mem_wb_stage;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          o_valid, o_rw, o_src, reg_we, fwd_valid;
   logic [DW-1:0] o_alu, o_mem, write_data, fwd_data;
   logic [AW-1:0] o_dest, fwd_reg;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0]   retire_cnt;
   logic [AW-1:0] last_dest;
`endif

   always #5 clk = ~clk;

   mem_wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

   mem_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .ex_mem                    (bus),
      .mem_wb_out_valid          (o_valid),
      .mem_wb_out_RegWrite       (o_rw),
      .mem_wb_out_RegSrc         (o_src),
      .mem_wb_out_ALUOut_EXEC    (o_alu),
      .mem_wb_out_Mem_dataOut    (o_mem),
      .mem_wb_out_write_reg_dest (o_dest),
      .write_data                (write_data),
      .reg_we                    (reg_we),
      .fwd_valid                 (fwd_valid),
      .fwd_reg                   (fwd_reg),
      .fwd_data                  (fwd_data)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .retire_cnt                (retire_cnt),
      .last_dest                 (last_dest)
`endif
   );

   // register file consuming the write port
   logic [DW-1:0] rf [32];
   always @(posedge clk) if (reg_we) rf[fwd_reg] <= write_data;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, rw, src, wb, input logic [31:0] alu,
                        input logic [4:0] dest, input logic [31:0] rd, input logic st, fl);
      bus.ex_mem_valid          = v;
      bus.ex_mem_RegWrite       = rw;
      bus.ex_mem_RegSrc         = src;
      bus.ex_mem_word_byte      = wb;
      bus.ex_mem_ALUOut_EXEC    = alu;
      bus.ex_mem_write_reg_dest = dest;
      bus.Read_data             = rd;
      bus.stall                 = st;
      bus.flush                 = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // behavioural model: what instruction currently sits in writeback
   typedef struct {
      bit          v, rw, src;
      logic [31:0] alu, mem;
      logic [4:0]  dest;
   } wb_slot_t;
   wb_slot_t m;

   function automatic logic [31:0] ref_load(bit src, bit wb, logic [31:0] addr, logic [31:0] rd);
      int unsigned b;
      if (!src) return 32'h0;
      if (!wb) return rd;
      b = (rd >> ((addr % 4) * 8)) % 256;
      return (b >= 128) ? (32'hFFFFFF00 | b) : b;
   endfunction

   task automatic model_step();
      if (rst || bus.flush) begin
         m = '{v: 0, rw: 0, src: 0, alu: 0, mem: 0, dest: 0};
      end else if (!bus.stall) begin
         m.v    = bus.ex_mem_valid;
         m.rw   = bus.ex_mem_valid && bus.ex_mem_RegWrite;
         m.src  = bus.ex_mem_RegSrc;
         m.alu  = bus.ex_mem_ALUOut_EXEC;
         m.mem  = ref_load(bus.ex_mem_RegSrc, bus.ex_mem_word_byte, bus.ex_mem_ALUOut_EXEC, bus.Read_data);
         m.dest = bus.ex_mem_write_reg_dest;
      end
   endtask

   task automatic model_check(input int cyc);
      logic [31:0] ewd;
      bit          ewe;
      ewd = m.src ? m.mem : m.alu;
      ewe = m.rw && (m.dest != 0);
      chk($sformatf("rnd%0d valid", cyc), 32'(o_valid), 32'(m.v));
      chk($sformatf("rnd%0d RegWrite", cyc), 32'(o_rw), 32'(m.rw));
      chk($sformatf("rnd%0d Mem_dataOut", cyc), o_mem, m.mem);
      chk($sformatf("rnd%0d dest", cyc), 32'(fwd_reg), 32'(m.dest));
      chk($sformatf("rnd%0d write_data", cyc), write_data, ewd);
      chk($sformatf("rnd%0d reg_we", cyc), 32'(reg_we), 32'(ewe));
      chk($sformatf("rnd%0d fwd_data", cyc), fwd_data, ewd);
      chk($sformatf("rnd%0d fwd_valid", cyc), 32'(fwd_valid), 32'(ewe));
   endtask

   typedef struct {
      logic        v, rw, src, wb;
      logic [31:0] alu;
      logic [4:0]  dest;
      logic [31:0] rd;
      logic        e_rw, e_we;
      logic [31:0] e_wd, e_mem;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{1, 1, 0, 0, 32'h0000_0002, 5'd22, 32'h0,         1, 1, 32'h0000_0002, 32'h0};
      tbl[1] = '{1, 1, 1, 1, 32'h0100_0001, 5'd5,  32'h123480FF,  1, 1, 32'hFFFF_FF80, 32'hFFFF_FF80};
      tbl[2] = '{1, 1, 1, 1, 32'h0000_1000, 5'd6,  32'h123480FF,  1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{1, 1, 1, 0, 32'h0000_1001, 5'd7,  32'h123480FF,  1, 1, 32'h1234_80FF, 32'h1234_80FF};
      tbl[4] = '{1, 1, 0, 0, 32'hDEAD_BEEF, 5'd0,  32'h123480FF,  1, 0, 32'hDEAD_BEEF, 32'h0};
      tbl[5] = '{1, 1, 1, 1, 32'h0000_0002, 5'd8,  32'h123480FF,  1, 1, 32'h0000_0034, 32'h0000_0034};
      tbl[6] = '{1, 0, 1, 1, 32'h0000_0003, 5'd9,  32'h123480FF,  0, 0, 32'h0000_0012, 32'h0000_0012};
      tbl[7] = '{0, 1, 0, 0, 32'h0000_0005, 5'd7,  32'h0,         0, 0, 32'h0000_0005, 32'h0};

      // reset state
      drive(1, 1, 0, 0, 32'h1111, 5'd3, 32'h0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst valid", 32'(o_valid), 32'h0);
      chk("rst RegWrite", 32'(o_rw), 32'h0);
      chk("rst write_data", write_data, 32'h0);
      chk("rst reg_we", 32'(reg_we), 32'h0);
      chk("rst ALUOut", o_alu, 32'h0);
      chk("rst dest", 32'(o_dest), 32'h0);

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].rw, tbl[i].src, tbl[i].wb, tbl[i].alu, tbl[i].dest, tbl[i].rd, 0, 0);
         tick();
         chk($sformatf("vec%0d write_data", i), write_data, tbl[i].e_wd);
         chk($sformatf("vec%0d reg_we", i), 32'(reg_we), 32'(tbl[i].e_we));
         chk($sformatf("vec%0d RegWrite", i), 32'(o_rw), 32'(tbl[i].e_rw));
         chk($sformatf("vec%0d Mem_dataOut", i), o_mem, tbl[i].e_mem);
         chk($sformatf("vec%0d fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].e_we));
         chk($sformatf("vec%0d fwd_reg", i), 32'(fwd_reg), 32'(tbl[i].dest));
         chk($sformatf("vec%0d fwd_data", i), fwd_data, tbl[i].e_wd);
         if (i == 1) chk("regfile[22]", rf[22], 32'h2);
      end

      // stall holds, then flush overrides stall
      drive(1, 1, 0, 0, 32'd7, 5'd9, 32'h0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 1, $urandom, 5'($urandom_range(1, 31)), $urandom, 1, 0);
         tick();
         chk($sformatf("stall%0d dest", i), 32'(fwd_reg), 32'd9);
         chk($sformatf("stall%0d write_data", i), write_data, 32'd7);
         chk($sformatf("stall%0d reg_we", i), 32'(reg_we), 32'h1);
      end
      drive(1, 1, 0, 0, 32'd44, 5'd10, 32'h0, 1, 1);
      tick();
      chk("flush valid", 32'(o_valid), 32'h0);
      chk("flush RegWrite", 32'(o_rw), 32'h0);
      chk("flush write_data", write_data, 32'h0);
      chk("flush reg_we", 32'(reg_we), 32'h0);

      // reset with a write in flight
      drive(1, 1, 0, 0, 32'h55, 5'd3, 32'h0, 0, 0);
      tick();
      chk("inflight reg_we", 32'(reg_we), 32'h1);
      drive(1, 1, 0, 0, 32'h66, 5'd4, 32'h0, 1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst valid", 32'(o_valid), 32'h0);
      chk("midrst write_data", write_data, 32'h0);
      chk("midrst reg_we", 32'(reg_we), 32'h0);
      chk("midrst dest", 32'(fwd_reg), 32'h0);
      drive(1, 1, 0, 0, 32'h66, 5'd4, 32'h0, 0, 0);
      tick();
      chk("postrst write_data", write_data, 32'h66);
      chk("postrst reg_we", 32'(reg_we), 32'h1);
      chk("postrst dest", 32'(fwd_reg), 32'd4);

`ifdef MEM_WB_RETIRE_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("retire rst cnt", retire_cnt, 32'h0);
      drive(1, 1, 0, 0, 32'd1, 5'd1, 32'h0, 0, 0); tick();
      drive(1, 1, 0, 0, 32'd2, 5'd2, 32'h0, 0, 0); tick();
      drive(1, 1, 0, 0, 32'd3, 5'd3, 32'h0, 1, 0); tick();
      drive(1, 1, 0, 0, 32'd3, 5'd3, 32'h0, 0, 0); tick();
      drive(1, 1, 0, 0, 32'd9, 5'd9, 32'h0, 0, 1); tick();
      drive(1, 1, 0, 0, 32'd4, 5'd4, 32'h0, 0, 0); tick();
      drive(1, 1, 0, 0, 32'd5, 5'd5, 32'h0, 0, 0); tick();
      drive(0, 0, 0, 0, 32'd0, 5'd0, 32'h0, 0, 0); tick();
      chk("retire cnt", retire_cnt, 32'd5);
      chk("retire last_dest", 32'(last_dest), 32'd5);
      tick();
      chk("retire cnt idle", retire_cnt, 32'd5);
`endif

      // randomized run against the model
      for (int c = 0; c < 400; c++) begin
         rst = (c == 0) || ($urandom_range(39) == 0);
         drive($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
               $urandom, ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom), $urandom,
               $urandom_range(3) == 0, $urandom_range(7) == 0);
         model_step();
         tick();
         model_check(c);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
